uart_rx_ctrl: RTL and testbench

Frame-sequencing controller for the UART receiver. It runs on the oversampled clock and tracks the position inside a frame with an edge counter and a bit counter. It decodes a start/data/parity/stop state machine into one-hot enables for the data sampler, start checker, deserializer, parity checker and stop checker. It combines their error flags into a single-cycle `data_valid` per good frame.

---
 rtl/uart_rx_ctrl_if.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART RX frame controller and its line/checker side.
// Optional err_clr/err_status appear with UART_RX_ERR_STATUS_EN.
interface uart_rx_ctrl_if #(
   parameter int PRESCALE_W = 6
);
   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic                  par_en;
   logic                  strt_glitch;
   logic                  par_err;
   logic                  stp_err;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  dat_samp_en;
   logic                  strt_chk_en;
   logic                  deser_en;
   logic                  par_chk_en;
   logic                  stp_chk_en;
   logic                  data_valid;
`ifdef UART_RX_ERR_STATUS_EN
   logic                  err_clr;
   logic [2:0]            err_status;

   modport master (
      input  rx_in, prescale, par_en,
      input  strt_glitch, par_err, stp_err,
      input  err_clr,
      output edge_cnt, bit_cnt,
      output dat_samp_en, strt_chk_en, deser_en,
      output par_chk_en, stp_chk_en, data_valid,
      output err_status
   );

   modport slave (
      output rx_in, prescale, par_en,
      output strt_glitch, par_err, stp_err,
      output err_clr,
      input  edge_cnt, bit_cnt,
      input  dat_samp_en, strt_chk_en, deser_en,
      input  par_chk_en, stp_chk_en, data_valid,
      input  err_status
   );
`else
   modport master (
      input  rx_in, prescale, par_en,
      input  strt_glitch, par_err, stp_err,
      output edge_cnt, bit_cnt,
      output dat_samp_en, strt_chk_en, deser_en,
      output par_chk_en, stp_chk_en, data_valid
   );

   modport slave (
      output rx_in, prescale, par_en,
      output strt_glitch, par_err, stp_err,
      input  edge_cnt, bit_cnt,
      input  dat_samp_en, strt_chk_en, deser_en,
      input  par_chk_en, stp_chk_en, data_valid
   );
`endif
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: edge/bit counters, Moore enables, data_valid.
// Define UART_RX_ERR_STATUS_EN for sticky err_status with err_clr.
module uart_rx_ctrl #(
   parameter int PRESCALE_W = 6,
   parameter int DATA_W     = 8
) (
   input logic            clk_based_on_prescale,
   input logic            asy_reset,
   uart_rx_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_W);

   state_t                state;
   state_t                state_n;
   logic [PRESCALE_W-1:0] p_eff;
   logic [PRESCALE_W-1:0] p_reg;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  fail;
   logic                  last;
   logic                  dat_samp_en;
   logic                  strt_chk_en;
   logic                  deser_en;
   logic                  par_chk_en;
   logic                  stp_chk_en;
   logic                  data_valid;

   // Only 16 and 32 are honoured; everything else falls back to 8.
   always_comb begin
      p_eff = PRESCALE_W'(8);
      if (bus.prescale == PRESCALE_W'(16))
         p_eff = PRESCALE_W'(16);
      else if (bus.prescale == PRESCALE_W'(32))
         p_eff = PRESCALE_W'(32);
   end

   assign last = (edge_cnt == p_reg - PRESCALE_W'(1));

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:
            if (!bus.rx_in) state_n = START;
         START:
            if (last) state_n = bus.strt_glitch ? IDLE : DATA;
         DATA:
            if (last && bit_cnt == LAST_BIT)
               state_n = bus.par_en ? PARITY : STOP;
         PARITY:
            if (last) state_n = STOP;
         STOP:
            if (last) state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         state       <= IDLE;
         p_reg       <= '0;
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         fail        <= 1'b0;
         dat_samp_en <= 1'b0;
         strt_chk_en <= 1'b0;
         deser_en    <= 1'b0;
         par_chk_en  <= 1'b0;
         stp_chk_en  <= 1'b0;
         data_valid  <= 1'b0;
      end else begin
         state       <= state_n;
         dat_samp_en <= (state_n != IDLE);
         strt_chk_en <= (state_n == START);
         deser_en    <= (state_n == DATA);
         par_chk_en  <= (state_n == PARITY);
         stp_chk_en  <= (state_n == STOP);
         data_valid  <= (state == STOP) && last &&
                        !bus.stp_err && !fail;

         if (state == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            if (!bus.rx_in) begin
               p_reg <= p_eff;
               fail  <= 1'b0;
            end
         end else if (state_n == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
         end else if (last) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
         end

         if (state == PARITY && last)
            fail <= bus.par_err;
      end
   end

`ifdef UART_RX_ERR_STATUS_EN
   logic [2:0] err_status;
   logic [2:0] err_set;

   assign err_set = {
      (state == STOP)   && last && bus.stp_err,
      (state == PARITY) && last && bus.par_err,
      (state == START)  && last && bus.strt_glitch
   };

   // A new error in the clear cycle survives the clear.
   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset)
         err_status <= '0;
      else
         err_status <= (err_status & ~{3{bus.err_clr}}) | err_set;
   end

   assign bus.err_status = err_status;
`endif

   assign bus.edge_cnt    = edge_cnt;
   assign bus.bit_cnt     = bit_cnt;
   assign bus.dat_samp_en = dat_samp_en;
   assign bus.strt_chk_en = strt_chk_en;
   assign bus.deser_en    = deser_en;
   assign bus.par_chk_en  = par_chk_en;
   assign bus.stp_chk_en  = stp_chk_en;
   assign bus.data_valid  = data_valid;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames push expected pulse cycles,
// a monitor pops them on data_valid.
module tb_uart_rx_ctrl;

   localparam int PW = 6;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus();

   uart_rx_ctrl #(
      .PRESCALE_W(PW),
      .DATA_W    (DW)
   ) dut (
      .clk_based_on_prescale(clk),
      .asy_reset            (rst_n),
      .bus                  (bus)
   );

   task automatic check(string nm, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d",
                  nm, cyc, act, exp);
      end
   endtask

   function automatic int ens();
      return {bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
              bus.par_chk_en, bus.stp_chk_en};
   endfunction

   function automatic int peff(int ps);
      if (ps == 16) return 16;
      if (ps == 32) return 32;
      return 8;
   endfunction

   // {dat_samp, strt_chk, deser, par_chk, stp_chk} for bit b
   function automatic int exp_ens(int b, bit par);
      if (b == 0) return 5'b11000;
      if (b <= DW) return 5'b10100;
      if (par && b == DW + 1) return 5'b10010;
      return 5'b10001;
   endfunction

   function automatic logic line_bit(int b, bit par, logic [7:0] d);
      if (b == 0) return 1'b0;
      if (b <= DW) return d[b-1];
      if (par && b == DW + 1) return ^d;
      return 1'b1;
   endfunction

   // Monitor: every data_valid must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.data_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid at cycle %0d: got 1 want 0",
                     cyc);
         end else begin
            check("valid_cycle", cyc, exp_q.pop_front());
         end
      end
   end

   task automatic clr_in();
      bus.strt_glitch = 1'b0;
      bus.par_err     = 1'b0;
      bus.stp_err     = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         check("idle_ens", ens(), 0);
         check("idle_edge", bus.edge_cnt, 0);
         check("idle_bit", bus.bit_cnt, 0);
         bus.rx_in = 1'b1;
         clr_in();
      end
   endtask

   task automatic send_frame(int ps, bit par, logic [7:0] d, bit gl,
                             bit perr, bit serr, bit good, int stop_at);
      int p;
      int len;
      int st;
      int b;
      int n;
      p   = peff(ps);
      len = (2 + DW + int'(par)) * p;
      @(negedge clk);
      clr_in();
      bus.prescale = PW'(ps);
      bus.par_en   = par;
      bus.rx_in    = 1'b0;
      st = cyc + 1;
      if (good) exp_q.push_back(st + len);
      n = gl ? p : ((stop_at > 0) ? stop_at : len);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         b = i / p;
         check("edge_cnt", bus.edge_cnt, i % p);
         check("bit_cnt", bus.bit_cnt, b);
         check("enables", ens(), exp_ens(b, par));
         if (i == 2) bus.prescale = PW'((p == 16) ? 8 : 16);
         bus.rx_in       = line_bit(b, par, d);
         bus.strt_glitch = gl && (i == p - 1);
         bus.par_err     = perr && par && (b == DW + 1) && (i % p == p - 1);
         bus.stp_err     = serr && (i == len - 1);
         if (gl && i == p - 1) bus.rx_in = 1'b1;
      end
   endtask

`ifdef UART_RX_ERR_STATUS_EN
   task automatic chk_err(int exp);
      check("err_status", int'(bus.err_status), exp);
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      check("err_cleared", int'(bus.err_status), 0);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog at cycle %0d: got timeout want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_in    = 1'b1;
      bus.prescale = PW'(8);
      bus.par_en   = 1'b0;
      clr_in();
`ifdef UART_RX_ERR_STATUS_EN
      bus.err_clr  = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ens", ens(), 0);
      check("rst_edge", bus.edge_cnt, 0);
      check("rst_bit", bus.bit_cnt, 0);
      check("rst_valid", bus.data_valid, 0);
`ifdef UART_RX_ERR_STATUS_EN
      check("rst_err", int'(bus.err_status), 0);
`endif
      rst_n = 1'b1;
      idle(3);

      // P=8 with even parity, 0xA5: pulse 88 cycles after START
      send_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      idle(4);

      // P=16, no parity, 0x3C: 160 cycles
      send_frame(16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      idle(4);

      // Start glitch: back to IDLE at cycle 8
      send_frame(8, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      check("glitch_ens", ens(), 0);
      check("glitch_edge", bus.edge_cnt, 0);
      check("glitch_bit", bus.bit_cnt, 0);
`ifdef UART_RX_ERR_STATUS_EN
      chk_err(3'b001);
`endif
      idle(3);

      // Parity error suppresses the pulse
      send_frame(8, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(1);
`ifdef UART_RX_ERR_STATUS_EN
      chk_err(3'b010);
`endif
      idle(3);

      // Back-to-back: second START from the data_valid cycle
      send_frame(8, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      send_frame(8, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      idle(4);

      // Illegal prescale 5 runs as 8: 80 cycles
      send_frame(5, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      idle(4);

      // Stop error suppresses the pulse
      send_frame(8, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      idle(1);
`ifdef UART_RX_ERR_STATUS_EN
      chk_err(3'b100);
`endif
      idle(3);

      // Async reset in the middle of DATA
      send_frame(8, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 30);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ens", ens(), 0);
      check("arst_edge", bus.edge_cnt, 0);
      check("arst_bit", bus.bit_cnt, 0);
      check("arst_valid", bus.data_valid, 0);
      bus.rx_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      check("pending_valid", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
